// File: rtl/mmss_countdown_timer_pkg.sv
// Shared state encoding and BCD constants for the mm:ss countdown timer.
// Declarations only: no latency, no flow control.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam int         SECONDS_PER_MIN = 60;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/mmss_countdown_timer_bcd_down_digit.sv
// One BCD digit register: clear > load > shift > decrement, wrapping to WRAP on borrow.
// Updates one cycle after the control strobe; never stalls.
module bcd_down_digit
  import timer_pkg::*;
#(
  parameter logic [3:0] WRAP = BCD_MAX
) (
  input  logic       clock,
  input  logic       Cn,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       shift_en,
  input  logic [3:0] shift_in,
  input  logic       borrow_in,
  output logic [3:0] q,
  output logic       borrow_out,
  output logic       is_zero
);

  assign is_zero    = (q == 4'd0);
  assign borrow_out = borrow_in && is_zero;

  always_ff @(posedge clock or negedge Cn) begin
    if (!Cn) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift_en) begin
      q <= shift_in;
    end else if (borrow_in) begin
      q <= is_zero ? WRAP : q - 4'd1;
    end
  end

endmodule

// File: rtl/mmss_countdown_timer.sv
// BCD mm:ss countdown with keypad entry, start/pause/cancel FSM, quick-add and per-second prescaler.
// Strobes take effect at the sampling edge; first decrement TICK_DIV cycles after start; no backpressure.
module mmss_countdown_timer
  import timer_pkg::*;
#(
  parameter int MIN_DIGITS  = 1,
  parameter int TICK_DIV    = 1,
  parameter int ADD_SECONDS = 30
) (
  input  logic                    clock,
  input  logic                    Cn,
  input  logic                    key_valid,
  input  logic [3:0]              key_digit,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    cancel,
  input  logic                    add,
  output logic [3:0]              sec_unidade,
  output logic [3:0]              sec_decimal,
  output logic [4*MIN_DIGITS-1:0] min,
  output logic                    running,
  output logic                    zero,
  output logic                    done
);

  localparam int             ND         = 2 + MIN_DIGITS;
  localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [11:0]    MAX_MIN    = 12'(pow10(MIN_DIGITS) - 1);

  state_t        state, state_nxt;
  logic [PW-1:0] presc;

  // Digit 0 = seconds units, 1 = seconds tens, 2.. = minutes LSD upward.
  logic [3:0]    dig_q     [ND];
  logic [3:0]    shift_src [ND];
  logic [3:0]    load_val  [ND];
  logic [ND-1:0] dig_zero;
  logic [ND:0]   brw;
  logic          msd_borrow_unused;

  logic do_start, do_pause, do_add, do_key, do_tick, hits_zero;
  logic dig_load, shift_en;
  logic [11:0] min_bin, min_sum;
  logic [7:0]  sec_total, sec_norm;
  logic [1:0]  min_carry;

  assign zero = &dig_zero;

  // Only strobes that are legal in the current state claim priority.
  assign do_start = !cancel && start &&
                    ((state == IDLE && !zero) || state == PAUSED);
  assign do_pause = !cancel && pause && (state == RUNNING);
  assign do_add   = !cancel && !do_start && !do_pause && add && (state != DONE);
  assign do_key   = !cancel && !do_start && !do_pause && !do_add && key_valid &&
                    (key_digit <= BCD_MAX) && (state == IDLE || state == DONE);
  assign do_tick  = !cancel && !do_pause && !do_add && (state == RUNNING) &&
                    (presc == PRESC_LAST);

  // A running value is never zero, so only 0:01 can decrement to zero.
  assign hits_zero = do_tick && (dig_q[0] == 4'd1) && (&dig_zero[ND-1:1]);

  assign dig_load = do_add || (do_key && state == DONE);
  assign shift_en = do_key && (state == IDLE);

  always_comb begin
    min_bin = '0;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      min_bin = min_bin + 12'(int'(dig_q[2+i]) * pow10(i));
    end
    sec_total = 8'(int'(dig_q[1]) * 10 + int'(dig_q[0]) + ADD_SECONDS);
    min_carry = 2'(sec_total / 8'(SECONDS_PER_MIN));
    sec_norm  = 8'(sec_total % 8'(SECONDS_PER_MIN));
    min_sum   = min_bin + {10'd0, min_carry};

    for (int i = 0; i < ND; i++) load_val[i] = 4'd0;
    if (do_key) begin
      load_val[0] = key_digit;
    end else if (min_sum > MAX_MIN) begin
      load_val[0] = BCD_MAX;
      load_val[1] = SEC_TENS_MAX;
      for (int i = 0; i < MIN_DIGITS; i++) load_val[2+i] = BCD_MAX;
    end else begin
      load_val[0] = 4'(sec_norm % 8'd10);
      load_val[1] = 4'(sec_norm / 8'd10);
      for (int i = 0; i < MIN_DIGITS; i++) begin
        load_val[2+i] = 4'((int'(min_sum) / pow10(i)) % 10);
      end
    end
  end

  assign shift_src[0]      = key_digit;
  assign brw[0]            = do_tick;
  assign msd_borrow_unused = brw[ND];

  for (genvar g = 0; g < ND; g++) begin : g_digit
    if (g > 0) begin : g_src
      assign shift_src[g] = dig_q[g-1];
    end

    bcd_down_digit #(
      .WRAP(g == 1 ? SEC_TENS_MAX : BCD_MAX)
    ) u_digit (
      .clock      (clock),
      .Cn         (Cn),
      .clear      (cancel),
      .load       (dig_load),
      .load_val   (load_val[g]),
      .shift_en   (shift_en),
      .shift_in   (shift_src[g]),
      .borrow_in  (brw[g]),
      .q          (dig_q[g]),
      .borrow_out (brw[g+1]),
      .is_zero    (dig_zero[g])
    );

    if (g >= 2) begin : g_min
      assign min[4*(g-2) +: 4] = dig_q[g];
    end
  end

  assign sec_unidade = dig_q[0];
  assign sec_decimal = dig_q[1];

  always_comb begin
    state_nxt = state;
    if (cancel) begin
      state_nxt = IDLE;
    end else if (do_start) begin
      state_nxt = RUNNING;
    end else if (do_pause) begin
      state_nxt = PAUSED;
    end else if (do_add) begin
      if (state == IDLE) state_nxt = RUNNING;
    end else if (do_key) begin
      state_nxt = IDLE;
    end else if (hits_zero) begin
      state_nxt = DONE;
    end
  end

  always_ff @(posedge clock or negedge Cn) begin
    if (!Cn) begin
      state   <= IDLE;
      presc   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == RUNNING);
      done    <= hits_zero;
      if (cancel || do_start || do_add) begin
        presc <= '0;
      end else if (state == RUNNING) begin
        presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mmss_countdown_timer.sv
// Directed bench for mmss_countdown_timer (MIN_DIGITS=1, TICK_DIV=4, ADD_SECONDS=30).
module tb_mmss_countdown_timer;

  logic        clock = 1'b0;
  logic        Cn;
  logic        key_valid, start, pause, cancel, add;
  logic [3:0]  key_digit;
  logic [3:0]  sec_unidade, sec_decimal, min;
  logic        running, zero, done;
  logic [11:0] disp;
  int          checks = 0;
  int          bad = 0;

  always #5 clock = ~clock;

  mmss_countdown_timer #(
    .MIN_DIGITS (1),
    .TICK_DIV   (4),
    .ADD_SECONDS(30)
  ) dut (
    .clock      (clock),
    .Cn         (Cn),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .start      (start),
    .pause      (pause),
    .cancel     (cancel),
    .add        (add),
    .sec_unidade(sec_unidade),
    .sec_decimal(sec_decimal),
    .min        (min),
    .running    (running),
    .zero       (zero),
    .done       (done)
  );

  assign disp = {min, sec_decimal, sec_unidade};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    key_digit = d;
    key_valid = 1'b1;
    step(1);
    key_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    step(1);
    cancel = 1'b0;
  endtask

  task automatic do_add();
    add = 1'b1;
    step(1);
    add = 1'b0;
  endtask

  initial begin
    Cn = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
    start = 1'b0; pause = 1'b0; cancel = 1'b0; add = 1'b0;
    #12;
    check("rst_disp", disp, 12'h000);
    check("rst_zero", zero, 1'b1);
    check("rst_running", running, 1'b0);
    check("rst_done", done, 1'b0);
    Cn = 1'b1;
    step(1);

    // Asynchronous reset in the middle of a run
    press(4'd2); press(4'd0);
    do_start();
    step(6);
    check("midrun_val", disp, 12'h019);
    #2 Cn = 1'b0;
    #1;
    check("arst_disp", disp, 12'h000);
    check("arst_zero", zero, 1'b1);
    check("arst_running", running, 1'b0);
    check("arst_done", done, 1'b0);
    Cn = 1'b1;
    step(1);
    press(4'd7);
    check("post_rst_key", disp, 12'h007);
    press(4'hC);
    check("key_gt9_ignored", disp, 12'h007);
    do_cancel();

    // 1:30 countdown to zero
    press(4'd1);
    check("key1", disp, 12'h001);
    check("key1_zero", zero, 1'b0);
    press(4'd3); press(4'd0);
    check("keys130", disp, 12'h130);
    do_start();
    check("start_running", running, 1'b1);
    step(3);
    check("before_first_tick", disp, 12'h130);
    step(1);
    check("first_tick", disp, 12'h129);
    step(355);
    check("one_sec_left", disp, 12'h001);
    check("no_done_yet", done, 1'b0);
    step(1);
    check("hit_zero", disp, 12'h000);
    check("done_pulse", done, 1'b1);
    check("zero_at_done", zero, 1'b1);
    check("stopped_at_done", running, 1'b0);
    step(1);
    check("done_one_cycle", done, 1'b0);

    // From DONE: key clears and enters 1:00, then double borrow
    press(4'd1);
    check("done_key_clear", disp, 12'h001);
    press(4'd0); press(4'd0);
    check("keys100", disp, 12'h100);
    do_start();
    step(4);
    check("double_borrow", disp, 12'h059);
    do_cancel();
    check("cancel_disp", disp, 12'h000);
    check("cancel_running", running, 1'b0);

    // Tens digit 9 counts down as-is, then reloads with 5
    press(4'd9); press(4'd0);
    check("keys090", disp, 12'h090);
    do_start();
    step(40);
    check("ten_ticks", disp, 12'h080);
    step(4);
    check("tens_borrow", disp, 12'h079);
    do_cancel();

    // Pause coincident with a tick, then resume
    press(4'd4); press(4'd5);
    do_start();
    step(3);
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    check("pause_running", running, 1'b0);
    check("pause_on_tick", disp, 12'h045);
    step(20);
    check("paused_hold", disp, 12'h045);
    do_start();
    check("resume_running", running, 1'b1);
    step(3);
    check("resume_phase", disp, 12'h045);
    step(1);
    check("resume_tick", disp, 12'h044);
    do_cancel();
    do_start();
    check("start_at_zero", running, 1'b0);

    // Quick-add
    do_add();
    check("add_idle", disp, 12'h030);
    check("add_idle_run", running, 1'b1);
    do_cancel();
    press(4'd5); press(4'd0);
    do_start();
    do_add();
    check("add_050", disp, 12'h120);
    step(3);
    check("add_presc_clr", disp, 12'h120);
    step(1);
    check("add_then_tick", disp, 12'h119);
    do_cancel();
    press(4'd9); press(4'd5); press(4'd0);
    check("keys950", disp, 12'h950);
    do_add();
    check("add_clamp", disp, 12'h959);
    check("add_clamp_run", running, 1'b1);

    // Cancel mid-run never produces done
    step(2);
    do_cancel();
    check("cancel_run_disp", disp, 12'h000);
    check("cancel_run_running", running, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("cancel_no_done", done, 1'b0);
      step(1);
    end

    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end

endmodule
